// File: rtl/bg_tile_fetcher_if.sv
// Bundle of scanline, VRAM and pixel-shifter signals for the background tile fetcher.
// Latency: none, this is wiring only. Window members exist only when BGFETCH_WINDOW_EN is defined.
// Backpressure: shifter_empty from the shifter side holds the fetcher in WAIT.
interface bg_tile_fetcher_if;
    logic        line_start;
    logic [7:0]  scx;
    logic [7:0]  scy;
    logic [7:0]  ly;
    logic        map_sel;
    logic        tile_sel;
    logic [7:0]  md;
    logic [12:0] ma;
    logic        vram_rd;
    logic        shifter_empty;
    logic        load;
    logic [7:0]  tile_lo;
    logic [7:0]  tile_hi;
`ifdef BGFETCH_WINDOW_EN
    logic        win_start;
    logic [7:0]  win_line;
    logic        win_map_sel;

    // Fetcher side: issues VRAM reads and loads the shifter.
    modport master (
        input  line_start, scx, scy, ly, map_sel, tile_sel, md, shifter_empty,
        input  win_start, win_line, win_map_sel,
        output ma, vram_rd, load, tile_lo, tile_hi
    );

    // Environment side: timing generator, VRAM and pixel shifter.
    modport slave (
        output line_start, scx, scy, ly, map_sel, tile_sel, md, shifter_empty,
        output win_start, win_line, win_map_sel,
        input  ma, vram_rd, load, tile_lo, tile_hi
    );
`else
    // Fetcher side: issues VRAM reads and loads the shifter.
    modport master (
        input  line_start, scx, scy, ly, map_sel, tile_sel, md, shifter_empty,
        output ma, vram_rd, load, tile_lo, tile_hi
    );

    // Environment side: timing generator, VRAM and pixel shifter.
    modport slave (
        output line_start, scx, scy, ly, map_sel, tile_sel, md, shifter_empty,
        input  ma, vram_rd, load, tile_lo, tile_hi
    );
`endif
endinterface

// File: rtl/bg_tile_fetcher.sv
// Background tile fetcher: map byte, then plane-0 and plane-1 bytes, then a parallel load into the pixel shifter.
// Latency: 6 fetch cycles plus 1 WAIT cycle per tile. ma/vram_rd are registered, load is asserted in the WAIT cycle itself.
// Backpressure: holds in WAIT while shifter_empty=0. Optional window restart is under BGFETCH_WINDOW_EN.
module bg_tile_fetcher (
    input  logic            clk,
    input  logic            reset,
    bg_tile_fetcher_if.master bus
);
    typedef enum logic [2:0] {IDLE, MAP_A, MAP_D, LO_A, LO_D, HI_A, HI_D, WAIT} state_t;

    state_t      state;
    logic [4:0]  xcnt;
    logic [4:0]  col0;
    logic [7:0]  yline;
    logic [7:0]  tile_num;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [7:0]  tile_lo_q;
    logic [7:0]  tile_hi_q;
    logic [12:0] ma_q;
    logic        rd_q;

    logic [7:0]  line_y;
    logic [4:0]  next_col;
    logic        map_bit;
    logic        restart_win;
    logic        load_now;

    // Fine scroll X selects a pixel inside the first tile and is consumed downstream, not here.
    logic unused_scx_fine;
    assign unused_scx_fine = &{1'b0, bus.scx[2:0]};

    function automatic logic [12:0] map_addr(input logic mb, input logic [7:0] yl, input logic [4:0] col);
        return {2'b11, mb, yl[7:3], col};
    endfunction

    // Unsigned mode indexes from 0x0000; signed mode flips bit 12 so tiles 0x80..0xFF land below 0x1000.
    function automatic logic [12:0] tile_addr(input logic sel, input logic [7:0] tn,
                                              input logic [2:0] row, input logic plane);
        return {(sel ? 1'b0 : ~tn[7]), tn, row, plane};
    endfunction

    assign line_y   = bus.ly + bus.scy;
    assign next_col = col0 + xcnt + 5'd1;

`ifdef BGFETCH_WINDOW_EN
    logic win_mode;
    logic win_map_q;
    assign restart_win = bus.win_start && (state != IDLE);
    assign map_bit     = win_mode ? win_map_q : bus.map_sel;
`else
    assign restart_win = 1'b0;
    assign map_bit     = bus.map_sel;
`endif

    // Load fires in the WAIT cycle itself; a restart or reset in the same cycle suppresses it.
    assign load_now = (state == WAIT) && bus.shifter_empty && !bus.line_start && !restart_win && !reset;

    assign bus.ma      = ma_q;
    assign bus.vram_rd = rd_q;
    assign bus.load    = load_now;
    // The fresh bytes appear together with load and stay put until the next load.
    assign bus.tile_lo = load_now ? lo : tile_lo_q;
    assign bus.tile_hi = load_now ? hi : tile_hi_q;

    // Fetch sequencer: state, captured VRAM bytes and the registered address/strobe for the next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            xcnt      <= '0;
            col0      <= '0;
            yline     <= '0;
            tile_num  <= '0;
            lo        <= '0;
            hi        <= '0;
            tile_lo_q <= '0;
            tile_hi_q <= '0;
            ma_q      <= '0;
            rd_q      <= 1'b0;
`ifdef BGFETCH_WINDOW_EN
            win_mode  <= 1'b0;
            win_map_q <= 1'b0;
`endif
        end else if (bus.line_start) begin
            state <= MAP_A;
            xcnt  <= '0;
            yline <= line_y;
            col0  <= bus.scx[7:3];
            ma_q  <= map_addr(bus.map_sel, line_y, bus.scx[7:3]);
            rd_q  <= 1'b1;
`ifdef BGFETCH_WINDOW_EN
            win_mode <= 1'b0;
`endif
        end
`ifdef BGFETCH_WINDOW_EN
        else if (restart_win) begin
            state     <= MAP_A;
            xcnt      <= '0;
            col0      <= '0;
            yline     <= bus.win_line;
            win_mode  <= 1'b1;
            win_map_q <= bus.win_map_sel;
            ma_q      <= map_addr(bus.win_map_sel, bus.win_line, 5'd0);
            rd_q      <= 1'b1;
        end
`endif
        else begin
            case (state)
                IDLE: begin
                    rd_q <= 1'b0;
                end
                MAP_A: begin
                    state <= MAP_D;
                    rd_q  <= 1'b0;
                end
                MAP_D: begin
                    tile_num <= bus.md;
                    state    <= LO_A;
                    ma_q     <= tile_addr(bus.tile_sel, bus.md, yline[2:0], 1'b0);
                    rd_q     <= 1'b1;
                end
                LO_A: begin
                    state <= LO_D;
                    rd_q  <= 1'b0;
                end
                LO_D: begin
                    lo    <= bus.md;
                    state <= HI_A;
                    ma_q  <= tile_addr(bus.tile_sel, tile_num, yline[2:0], 1'b1);
                    rd_q  <= 1'b1;
                end
                HI_A: begin
                    state <= HI_D;
                    rd_q  <= 1'b0;
                end
                HI_D: begin
                    hi    <= bus.md;
                    state <= WAIT;
                end
                WAIT: begin
                    rd_q <= 1'b0;
                    if (bus.shifter_empty) begin
                        tile_lo_q <= lo;
                        tile_hi_q <= hi;
                        xcnt      <= xcnt + 5'd1;
                        state     <= MAP_A;
                        ma_q      <= map_addr(map_bit, yline, next_col);
                        rd_q      <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    rd_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bg_tile_fetcher.sv
module tb_bg_tile_fetcher;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    bg_tile_fetcher_if bus();

    bg_tile_fetcher dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // From MAP_A (at posedge+1), runs one tile and stops in the first WAIT cycle.
    task automatic run_tile(input logic [7:0] t, input logic [7:0] l, input logic [7:0] h,
                            output logic [12:0] a_map, output logic [12:0] a_lo,
                            output logic [12:0] a_hi, output logic [5:0] rd);
        a_map = bus.ma; rd[5] = bus.vram_rd;
        cyc(); rd[4] = bus.vram_rd; bus.md = t;                    // MAP_D
        cyc(); rd[3] = bus.vram_rd; a_lo = bus.ma; bus.md = l;     // LO_A
        cyc(); rd[2] = bus.vram_rd;                                // LO_D
        cyc(); rd[1] = bus.vram_rd; a_hi = bus.ma; bus.md = h;     // HI_A
        cyc(); rd[0] = bus.vram_rd;                                // HI_D
        cyc();                                                     // WAIT
    endtask

    task automatic start_line(input logic [7:0] x, input logic [7:0] y, input logic [7:0] l);
        bus.scx = x; bus.scy = y; bus.ly = l; bus.line_start = 1'b1;
        cyc();
        bus.line_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.line_start = 1'b1;
`ifdef BGFETCH_WINDOW_EN
        bus.win_start = 1'b1;
`endif
        repeat (3) cyc();
        n_checks++; if (bus.ma !== 13'h0) begin n_fail++; $display("FAIL reset_ma got=%h exp=0", bus.ma); end
        n_checks++; if (bus.vram_rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd got=%b exp=0", bus.vram_rd); end
        n_checks++; if (bus.load !== 1'b0) begin n_fail++; $display("FAIL reset_load got=%b exp=0", bus.load); end
        n_checks++; if ({bus.tile_lo, bus.tile_hi} !== 16'h0) begin n_fail++; $display("FAIL reset_tile got=%h%h exp=0", bus.tile_lo, bus.tile_hi); end
        reset = 1'b0; bus.line_start = 1'b0;
`ifdef BGFETCH_WINDOW_EN
        bus.win_start = 1'b0;
`endif
        repeat (4) begin
            cyc();
            n_checks++; if (bus.vram_rd !== 1'b0 || bus.load !== 1'b0) begin n_fail++; $display("FAIL idle_hold rd=%b load=%b exp=0,0", bus.vram_rd, bus.load); end
        end
    endtask

    task automatic test_basic();
        logic [12:0] am, al, ah; logic [5:0] rd;
        bus.tile_sel = 1'b1; bus.map_sel = 1'b0; bus.shifter_empty = 1'b1;
        start_line(8'h00, 8'h00, 8'd3);
        n_checks++; if (bus.ma !== 13'h1800 || bus.vram_rd !== 1'b1) begin n_fail++; $display("FAIL first_map ma=%h rd=%b exp=1800,1", bus.ma, bus.vram_rd); end
        run_tile(8'h05, 8'hAA, 8'h55, am, al, ah, rd);
        n_checks++; if (al !== 13'h0056) begin n_fail++; $display("FAIL lo_addr got=%h exp=0056", al); end
        n_checks++; if (ah !== 13'h0057) begin n_fail++; $display("FAIL hi_addr got=%h exp=0057", ah); end
        n_checks++; if (rd !== 6'b101010) begin n_fail++; $display("FAIL rd_pattern got=%b exp=101010", rd); end
        n_checks++; if (bus.load !== 1'b1 || bus.tile_lo !== 8'hAA || bus.tile_hi !== 8'h55) begin n_fail++; $display("FAIL load_basic load=%b lo=%h hi=%h exp=1,aa,55", bus.load, bus.tile_lo, bus.tile_hi); end
        cyc();
        n_checks++; if (bus.load !== 1'b0 || bus.ma !== 13'h1801 || bus.tile_lo !== 8'hAA) begin n_fail++; $display("FAIL after_load load=%b ma=%h lo=%h exp=0,1801,aa", bus.load, bus.ma, bus.tile_lo); end
    endtask

    task automatic test_signed();
        logic [12:0] am, al, ah; logic [5:0] rd;
        bus.tile_sel = 1'b0;
        start_line(8'h00, 8'h00, 8'd0);
        run_tile(8'h80, 8'h11, 8'h22, am, al, ah, rd);
        n_checks++; if (al !== 13'h0800) begin n_fail++; $display("FAIL signed_80 got=%h exp=0800", al); end
        cyc();
        run_tile(8'h7F, 8'h3C, 8'hC3, am, al, ah, rd);
        n_checks++; if (al !== 13'h17F0 || ah !== 13'h17F1) begin n_fail++; $display("FAIL signed_7f lo=%h hi=%h exp=17f0,17f1", al, ah); end
        cyc();
        bus.tile_sel = 1'b1;
    endtask

    task automatic test_stall();
        logic [12:0] am, al, ah; logic [5:0] rd;
        bus.shifter_empty = 1'b0;
        start_line(8'h00, 8'h00, 8'd0);
        run_tile(8'h01, 8'h66, 8'h99, am, al, ah, rd);
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (bus.load !== 1'b0 || bus.vram_rd !== 1'b0 || bus.tile_lo !== 8'h3C || bus.tile_hi !== 8'hC3) begin
                n_fail++; $display("FAIL stall_%0d load=%b rd=%b lo=%h hi=%h exp=0,0,3c,c3", i, bus.load, bus.vram_rd, bus.tile_lo, bus.tile_hi);
            end
            cyc();
        end
        bus.shifter_empty = 1'b1;
        #1;
        n_checks++; if (bus.load !== 1'b1 || bus.tile_lo !== 8'h66 || bus.tile_hi !== 8'h99) begin n_fail++; $display("FAIL release_load load=%b lo=%h hi=%h exp=1,66,99", bus.load, bus.tile_lo, bus.tile_hi); end
        cyc();
        n_checks++; if (bus.load !== 1'b0 || bus.tile_lo !== 8'h66 || bus.ma !== 13'h1801) begin n_fail++; $display("FAIL post_release load=%b lo=%h ma=%h exp=0,66,1801", bus.load, bus.tile_lo, bus.ma); end
    endtask

    task automatic test_line_priority();
        logic [12:0] am, al, ah; logic [5:0] rd;
        start_line(8'h00, 8'h00, 8'd0);
        run_tile(8'h02, 8'h44, 8'h88, am, al, ah, rd);
        bus.ly = 8'd8; bus.line_start = 1'b1;
        #1;
        n_checks++; if (bus.load !== 1'b0 || bus.tile_lo !== 8'h66) begin n_fail++; $display("FAIL prio_noload load=%b lo=%h exp=0,66", bus.load, bus.tile_lo); end
        cyc();
        bus.line_start = 1'b0;
        n_checks++; if (bus.ma !== 13'h1820 || bus.vram_rd !== 1'b1) begin n_fail++; $display("FAIL prio_restart ma=%h rd=%b exp=1820,1", bus.ma, bus.vram_rd); end
        run_tile(8'h03, 8'h12, 8'h34, am, al, ah, rd);
        n_checks++; if (bus.load !== 1'b1 || bus.tile_lo !== 8'h12) begin n_fail++; $display("FAIL prio_next load=%b lo=%h exp=1,12", bus.load, bus.tile_lo); end
        cyc();
        n_checks++; if (bus.ma !== 13'h1821) begin n_fail++; $display("FAIL prio_col got=%h exp=1821", bus.ma); end
    endtask

    task automatic test_scx_wrap();
        logic [12:0] am, al, ah; logic [5:0] rd;
        start_line(8'hF8, 8'h00, 8'd0);
        run_tile(8'h04, 8'h01, 8'h02, am, al, ah, rd);
        n_checks++; if (am !== 13'h181F) begin n_fail++; $display("FAIL scx_col31 got=%h exp=181f", am); end
        cyc();
        n_checks++; if (bus.ma !== 13'h1800) begin n_fail++; $display("FAIL scx_col0 got=%h exp=1800", bus.ma); end
    endtask

    task automatic test_xcnt_wrap();
        logic [12:0] am, al, ah, exp_ma; logic [5:0] rd;
        start_line(8'h10, 8'h00, 8'd0);
        for (int i = 0; i < 32; i++) begin
            run_tile(i[7:0], i[7:0], ~i[7:0], am, al, ah, rd);
            exp_ma = 13'h1800 | 13'((2 + i) % 32);
            n_checks++; if (am !== exp_ma) begin n_fail++; $display("FAIL wrap_col_%0d got=%h exp=%h", i, am, exp_ma); end
            cyc();
        end
        n_checks++; if (bus.ma !== 13'h1802 || bus.tile_lo !== 8'd31 || bus.tile_hi !== 8'hE0) begin n_fail++; $display("FAIL wrap_end ma=%h lo=%h hi=%h exp=1802,1f,e0", bus.ma, bus.tile_lo, bus.tile_hi); end
    endtask

    task automatic test_reset_mid();
        start_line(8'h00, 8'h00, 8'd0);
        bus.md = 8'h09;
        repeat (5) cyc();                // now in HI_D
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        n_checks++; if (bus.load !== 1'b0 || bus.ma !== 13'h0 || bus.vram_rd !== 1'b0 || bus.tile_lo !== 8'h0 || bus.tile_hi !== 8'h0) begin
            n_fail++; $display("FAIL reset_mid load=%b ma=%h rd=%b lo=%h hi=%h exp=all 0", bus.load, bus.ma, bus.vram_rd, bus.tile_lo, bus.tile_hi);
        end
        repeat (8) begin
            cyc();
            n_checks++; if (bus.load !== 1'b0 || bus.vram_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mid_idle load=%b rd=%b exp=0,0", bus.load, bus.vram_rd); end
        end
    endtask

`ifdef BGFETCH_WINDOW_EN
    task automatic test_window();
        logic [12:0] am, al, ah; logic [5:0] rd;
        bus.win_start = 1'b1; bus.win_line = 8'h10; bus.win_map_sel = 1'b0;
        cyc();
        bus.win_start = 1'b0;
        n_checks++; if (bus.vram_rd !== 1'b0) begin n_fail++; $display("FAIL win_idle rd=%b exp=0", bus.vram_rd); end
        start_line(8'h00, 8'h00, 8'd0);
        repeat (3) cyc();                // LO_D
        bus.win_start = 1'b1;
        cyc();
        bus.win_start = 1'b0;
        n_checks++; if (bus.ma !== 13'h1840 || bus.vram_rd !== 1'b1) begin n_fail++; $display("FAIL win_restart ma=%h rd=%b exp=1840,1", bus.ma, bus.vram_rd); end
        run_tile(8'h06, 8'h5A, 8'hA5, am, al, ah, rd);
        n_checks++; if (bus.load !== 1'b1 || bus.tile_lo !== 8'h5A) begin n_fail++; $display("FAIL win_load load=%b lo=%h exp=1,5a", bus.load, bus.tile_lo); end
        cyc();
        n_checks++; if (bus.ma !== 13'h1841) begin n_fail++; $display("FAIL win_col1 got=%h exp=1841", bus.ma); end
        bus.line_start = 1'b1; bus.ly = 8'd8; bus.win_start = 1'b1; bus.win_line = 8'h30;
        cyc();
        bus.line_start = 1'b0; bus.win_start = 1'b0;
        n_checks++; if (bus.ma !== 13'h1820) begin n_fail++; $display("FAIL win_vs_line got=%h exp=1820", bus.ma); end
        cyc();
        bus.win_start = 1'b1; bus.win_line = 8'h10; bus.win_map_sel = 1'b1;
        cyc();
        bus.win_start = 1'b0;
        n_checks++; if (bus.ma !== 13'h1C40) begin n_fail++; $display("FAIL win_map1 got=%h exp=1c40", bus.ma); end
    endtask
`endif

    initial begin
        n_checks = 0; n_fail = 0;
        reset = 1'b1;
        bus.line_start = 1'b0; bus.scx = '0; bus.scy = '0; bus.ly = '0;
        bus.map_sel = 1'b0; bus.tile_sel = 1'b1; bus.md = '0; bus.shifter_empty = 1'b1;
`ifdef BGFETCH_WINDOW_EN
        bus.win_start = 1'b0; bus.win_line = '0; bus.win_map_sel = 1'b0;
`endif
        #1;
        test_reset();
        test_basic();
        test_signed();
        test_stall();
        test_line_priority();
        test_scx_wrap();
        test_xcnt_wrap();
        test_reset_mid();
`ifdef BGFETCH_WINDOW_EN
        test_window();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
